// File: rtl/credit_pkg.sv
// Shared definitions for both ends of the credit-based link:
// handshake state encoding and credit-counter width helper.
package credit_pkg;

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_WAIT_RX = 2'd1,
        S_ACTIVE  = 2'd2
    } state_e;

    function automatic int credit_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with clamped load
// and a sticky overflow flag for over-returned credits.
module credit_counter #(
    parameter int MAX_CREDITS = 4,
    parameter int WIDTH       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             full_o,
    output logic             overflow_o
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_CREDITS);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             inc_ok;

    assign full_o     = (count_q == MAX_C);
    assign inc_ok     = inc_i && !full_o;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    // Next count: reload while not active, otherwise net of send/return.
    always_comb begin
        load_d  = (load_val_i > MAX_C) ? MAX_C : load_val_i;
        count_d = count_q;
        if (!active_i) begin
            count_d = load_d;
        end else if (inc_ok && !dec_i) begin
            count_d = count_q + ONE;
        end else if (dec_i && !inc_ok) begin
            count_d = count_q - ONE;
        end
        ovf_d = ovf_q | (active_i & inc_i & full_o);
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= load_d;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/credit_sender.sv
// Transmit end of the credit link: reset handshake with the
// receiver, one credit spent per forwarded word.
module credit_sender
    import credit_pkg::*;
#(
    parameter int   DATA_WIDTH   = 8,
    parameter int   MAX_CREDITS  = 4,
    localparam int  CREDIT_WIDTH = credit_width(MAX_CREDITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [DATA_WIDTH-1:0]   push_data,
    output logic                    pop_sender_in_reset,
    input  logic                    pop_receiver_in_reset,
    output logic                    pop_credit_stall,
    input  logic                    pop_credit,
    output logic                    pop_valid,
    output logic [DATA_WIDTH-1:0]   pop_data,
    input  logic [CREDIT_WIDTH-1:0] credit_initial,
    input  logic [CREDIT_WIDTH-1:0] credit_withhold,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_available,
    output logic                    credit_overflow
);

    state_e                  state_q;
    logic                    sir_q;
    logic                    pop_valid_q;
    logic [DATA_WIDTH-1:0]   pop_data_q;
    logic                    active;
    logic                    full;
    logic                    send;

    assign active           = (state_q == S_ACTIVE);
    assign credit_available = (credit_count > credit_withhold);
    assign push_ready       = active && credit_available;
    assign pop_credit_stall = !active || full;
    assign send             = push_valid && push_ready;

    assign pop_sender_in_reset = sir_q;
    assign pop_valid           = pop_valid_q;
    assign pop_data            = pop_data_q;

    // Reset handshake FSM; in-reset flag registered alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            sir_q   <= 1'b1;
        end else begin
            sir_q <= 1'b0;
            unique case (state_q)
                S_RESET: begin
                    state_q <= S_WAIT_RX;
                end
                S_WAIT_RX: begin
                    if (!pop_receiver_in_reset) begin
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (pop_receiver_in_reset) begin
                        state_q <= S_WAIT_RX;
                    end
                end
                default: begin
                    state_q <= S_RESET;
                end
            endcase
        end
    end

    // One-cycle beat toward the receiver; data holds between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
        end else begin
            pop_valid_q <= send;
            if (send) begin
                pop_data_q <= push_data;
            end
        end
    end

    credit_counter #(
        .MAX_CREDITS (MAX_CREDITS),
        .WIDTH       (CREDIT_WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .active_i   (active),
        .inc_i      (pop_credit),
        .dec_i      (send),
        .load_val_i (credit_initial),
        .count_o    (credit_count),
        .full_o     (full),
        .overflow_o (credit_overflow)
    );

endmodule

// File: tb/tb_credit_sender.sv
// Bench for credit_sender: directed vector table plus
// randomized traffic checked against a cycle reference model.
module tb_credit_sender;

    localparam int DW   = 8;
    localparam int MAXC = 4;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_sender_in_reset;
    logic          pop_receiver_in_reset;
    logic          pop_credit_stall;
    logic          pop_credit;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic          credit_available;
    logic          credit_overflow;

    always #5 clk = ~clk;

    credit_sender #(
        .DATA_WIDTH  (DW),
        .MAX_CREDITS (MAXC)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .push_valid            (push_valid),
        .push_ready            (push_ready),
        .push_data             (push_data),
        .pop_sender_in_reset   (pop_sender_in_reset),
        .pop_receiver_in_reset (pop_receiver_in_reset),
        .pop_credit_stall      (pop_credit_stall),
        .pop_credit            (pop_credit),
        .pop_valid             (pop_valid),
        .pop_data              (pop_data),
        .credit_initial        (credit_initial),
        .credit_withhold       (credit_withhold),
        .credit_count          (credit_count),
        .credit_available      (credit_available),
        .credit_overflow       (credit_overflow)
    );

    typedef struct {
        logic          r, rx, pv;
        logic [DW-1:0] d;
        logic          cr;
        logic [CW-1:0] init, wh;
        int            cnt;
        logic          rdy, stl, pvo;
        logic [DW-1:0] pdo;
        logic          ovf, sir;
    } vec_t;

    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    // reference model: phase 0=reset, 1=waiting for rx, 2=running
    int            m_phase;
    int            m_cnt;
    logic          m_ovf, m_pv, m_sir;
    logic [DW-1:0] m_pd;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic add(input int r, rx, pv, d, cr, init, wh,
                       input int cnt, rdy, stl, pvo, pdo, ovf, sir);
        vec_t v;
        v.r = r[0];  v.rx = rx[0]; v.pv = pv[0]; v.d = d[DW-1:0];
        v.cr = cr[0]; v.init = init[CW-1:0]; v.wh = wh[CW-1:0];
        v.cnt = cnt; v.rdy = rdy[0]; v.stl = stl[0]; v.pvo = pvo[0];
        v.pdo = pdo[DW-1:0]; v.ovf = ovf[0]; v.sir = sir[0];
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, rx, pv, input logic [DW-1:0] d,
                         input logic cr, input logic [CW-1:0] init, wh);
        rst = r;
        pop_receiver_in_reset = rx;
        push_valid = pv;
        push_data = d;
        pop_credit = cr;
        credit_initial = init;
        credit_withhold = wh;
    endtask

    task automatic model_edge();
        logic act, rdy, stl, snd, acc;
        act = (m_phase == 2);
        rdy = act && (m_cnt > int'(credit_withhold));
        stl = !act || (m_cnt == MAXC);
        snd = push_valid && rdy;
        acc = pop_credit && !stl;
        if (rst) begin
            m_phase = 0;
            m_cnt = clampi(int'(credit_initial));
            m_ovf = 1'b0; m_pv = 1'b0; m_pd = '0; m_sir = 1'b1;
            exp_q.delete();
        end else begin
            m_pv = snd;
            if (snd) begin
                m_pd = push_data;
                exp_q.push_back(push_data);
            end
            if (act && pop_credit && m_cnt == MAXC) m_ovf = 1'b1;
            if (act) m_cnt = m_cnt - int'(snd) + int'(acc);
            else m_cnt = clampi(int'(credit_initial));
            if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1 && !pop_receiver_in_reset) m_phase = 2;
            else if (m_phase == 2 && pop_receiver_in_reset) m_phase = 1;
            m_sir = 1'b0;
        end
    endtask

    task automatic model_check();
        logic act;
        act = (m_phase == 2);
        chk("count", credit_count, m_cnt);
        chk("avail", credit_available, m_cnt > int'(credit_withhold));
        chk("ready", push_ready, act && m_cnt > int'(credit_withhold));
        chk("stall", pop_credit_stall, !act || m_cnt == MAXC);
        chk("ovf", credit_overflow, m_ovf);
        chk("sir", pop_sender_in_reset, m_sir);
        chk("pvalid", pop_valid, m_pv);
        chk("pdata", pop_data, m_pd);
        if (pop_valid === 1'b1) begin
            chk("sb_avail", exp_q.size(), 1);
            if (exp_q.size() > 0) chk("sb_data", pop_data, exp_q.pop_front());
        end
        chk("sb_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    initial begin
        logic rx;
        //  r rx pv d     cr in wh | cnt rdy stl pv pd    ovf sir
        add(1, 1, 0, 'h00, 0, 2, 0,  2, 0, 1, 0, 'h00, 0, 1);
        add(1, 1, 0, 'h00, 0, 2, 0,  2, 0, 1, 0, 'h00, 0, 1);
        add(1, 1, 0, 'h00, 0, 2, 0,  2, 0, 1, 0, 'h00, 0, 1);
        add(0, 1, 0, 'h00, 0, 2, 0,  2, 0, 1, 0, 'h00, 0, 0);
        add(0, 1, 0, 'h00, 0, 2, 0,  2, 0, 1, 0, 'h00, 0, 0);
        add(0, 1, 0, 'h00, 0, 2, 0,  2, 0, 1, 0, 'h00, 0, 0);
        add(0, 1, 0, 'h00, 0, 2, 0,  2, 0, 1, 0, 'h00, 0, 0);
        add(0, 0, 0, 'h00, 0, 2, 0,  2, 1, 0, 0, 'h00, 0, 0);
        add(0, 0, 1, 'hA1, 0, 2, 0,  1, 1, 0, 1, 'hA1, 0, 0);
        add(0, 0, 1, 'hA2, 0, 2, 0,  0, 0, 0, 1, 'hA2, 0, 0);
        add(0, 0, 1, 'hA3, 0, 2, 0,  0, 0, 0, 0, 'hA2, 0, 0);
        add(0, 0, 0, 'h00, 1, 2, 0,  1, 1, 0, 0, 'hA2, 0, 0);
        add(0, 0, 1, 'hB1, 1, 2, 0,  1, 1, 0, 1, 'hB1, 0, 0);
        add(0, 0, 0, 'h00, 1, 2, 0,  2, 1, 0, 0, 'hB1, 0, 0);
        add(0, 0, 0, 'h00, 1, 2, 0,  3, 1, 0, 0, 'hB1, 0, 0);
        add(0, 0, 0, 'h00, 1, 2, 0,  4, 1, 1, 0, 'hB1, 0, 0);
        add(0, 0, 0, 'h00, 1, 2, 0,  4, 1, 1, 0, 'hB1, 1, 0);
        add(0, 0, 1, 'hC1, 1, 2, 0,  3, 1, 0, 1, 'hC1, 1, 0);
        add(0, 0, 0, 'h00, 0, 2, 3,  3, 0, 0, 0, 'hC1, 1, 0);
        add(0, 0, 1, 'hD1, 0, 2, 3,  3, 0, 0, 0, 'hC1, 1, 0);
        add(0, 0, 1, 'hD2, 0, 2, 2,  2, 0, 0, 1, 'hD2, 1, 0);
        add(0, 0, 1, 'hD3, 0, 2, 2,  2, 0, 0, 0, 'hD2, 1, 0);
        add(0, 0, 1, 'hD4, 0, 2, 0,  1, 1, 0, 1, 'hD4, 1, 0);
        add(0, 1, 1, 'hD5, 0, 4, 0,  0, 0, 1, 1, 'hD5, 1, 0);
        add(0, 1, 0, 'h00, 0, 4, 0,  4, 0, 1, 0, 'hD5, 1, 0);
        add(0, 0, 0, 'h00, 0, 4, 0,  4, 1, 1, 0, 'hD5, 1, 0);
        add(0, 0, 1, 'hE1, 0, 4, 0,  3, 1, 0, 1, 'hE1, 1, 0);
        add(1, 0, 0, 'h00, 0, 7, 0,  4, 0, 1, 0, 'h00, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].rx, tbl[i].pv, tbl[i].d,
                  tbl[i].cr, tbl[i].init, tbl[i].wh);
            tick();
            chk($sformatf("v%0d_cnt", i), credit_count, tbl[i].cnt);
            chk($sformatf("v%0d_rdy", i), push_ready, tbl[i].rdy);
            chk($sformatf("v%0d_stall", i), pop_credit_stall, tbl[i].stl);
            chk($sformatf("v%0d_pvalid", i), pop_valid, tbl[i].pvo);
            chk($sformatf("v%0d_pdata", i), pop_data, tbl[i].pdo);
            chk($sformatf("v%0d_ovf", i), credit_overflow, tbl[i].ovf);
            chk($sformatf("v%0d_sir", i), pop_sender_in_reset, tbl[i].sir);
        end

        rx = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) rx = ~rx;
            drive(($urandom_range(0, 99) == 0), rx,
                  1'($urandom_range(0, 1)), DW'($urandom),
                  ($urandom_range(0, 2) == 0),
                  CW'($urandom_range(0, 7)), CW'($urandom_range(0, 4)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
